// File: rtl/s2p_align_ctrl_pkg.sv
// Shared definitions for the 4-lane serial-to-parallel alignment controller:
// FSM state encoding, lane count and the default comma byte.
package s2p_align_ctrl_pkg;

    localparam int unsigned NUM_LANES = 4;

    // Default comma; always byte 0 of every frame on lane 0.
    localparam logic [7:0] COM_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PRELOCK = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

endpackage

// File: rtl/s2p_align_ctrl_window.sv
// One lane's serial shift window: MSB-first bits shift in at the LSB on every
// enabled clock; synchronous active-low clear.
module s2p_window #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enb_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] win_o
);

    logic [WIDTH-1:0] win_q;
    logic [WIDTH-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (enb_i) begin
            win_d = {win_q[WIDTH-2:0], s_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/s2p_align_ctrl.sv
// Byte/frame alignment controller: finds the comma on lane 0, locks onto the
// frame phase and emits aligned 4-lane words with valid/sof pulses.
module s2p_align_ctrl
    import s2p_align_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_DEFAULT),
    parameter int unsigned      FRAME_LEN = 4,
    parameter int unsigned      LOCK_CNT  = 3,
    parameter int unsigned      LOSS_CNT  = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       ENB,
    input  logic [NUM_LANES-1:0]       s_in,
    output logic [NUM_LANES*WIDTH-1:0] data_out,
    output logic                       data_valid,
    output logic                       sof,
    output logic                       locked
);

    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  LOSS_VAL = BAD_W'(LOSS_CNT);

    state_e state_q;
    state_e state_d;

    logic [BIT_W-1:0]              bit_cnt_q;
    logic [BIT_W-1:0]              bit_cnt_d;
    logic [IDX_W-1:0]              byte_idx_q;
    logic [IDX_W-1:0]              byte_idx_d;
    logic [GOOD_W-1:0]             good_q;
    logic [GOOD_W-1:0]             good_d;
    logic [BAD_W-1:0]              bad_q;
    logic [BAD_W-1:0]              bad_d;
    logic [NUM_LANES*WIDTH-1:0]    data_q;
    logic [NUM_LANES*WIDTH-1:0]    data_d;
    logic                          valid_q;
    logic                          valid_d;
    logic                          sof_q;
    logic                          sof_d;

    logic [WIDTH-1:0]              win [NUM_LANES];
    logic [NUM_LANES*WIDTH-1:0]    lane_word;
    logic [GOOD_W-1:0]             good_inc;
    logic [BAD_W-1:0]              bad_inc;
    logic                          com_hit;
    logic                          boundary;
    logic                          frame_slot;
    logic                          good_done;
    logic                          bad_done;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        s2p_window #(
            .WIDTH(WIDTH)
        ) u_win (
            .clk_i (CLK),
            .rst_ni(reset),
            .enb_i (ENB),
            .s_i   (s_in[g]),
            .win_o (win[g])
        );
    end

    always_comb begin
        lane_word = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_word[i*WIDTH +: WIDTH] = win[i];
        end
    end

    // A boundary is an enabled cycle, while aligned, where the window holds a whole byte.
    assign com_hit    = (win[0] == COM);
    assign boundary   = ENB && (state_q == ST_PRELOCK || state_q == ST_LOCKED)
                        && (bit_cnt_q == '0);
    assign frame_slot = boundary && (byte_idx_q == '0);
    assign good_inc   = good_q + GOOD_W'(1);
    assign bad_inc    = bad_q + BAD_W'(1);
    assign good_done  = (good_inc == LOCK_VAL);
    assign bad_done   = (bad_inc == LOSS_VAL);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (ENB && com_hit) begin
                    state_d = ST_PRELOCK;
                end
            end
            ST_PRELOCK: begin
                if (frame_slot) begin
                    if (!com_hit) begin
                        state_d = ST_SEARCH;
                    end else if (good_done) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_slot && !com_hit && bad_done) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked     = (state_q == ST_LOCKED);
        data_valid = valid_q;
        sof        = sof_q;
        data_out   = data_q;
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        good_d     = good_q;
        bad_d      = bad_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        if (ENB) begin
            case (state_q)
                ST_SEARCH: begin
                    // The comma just seen is byte 0, so the next boundary is byte 1.
                    if (com_hit) begin
                        bit_cnt_d  = BIT_W'(1);
                        byte_idx_d = IDX_W'(1);
                        good_d     = GOOD_W'(1);
                        bad_d      = '0;
                    end
                end
                ST_PRELOCK, ST_LOCKED: begin
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
                    if (boundary) begin
                        byte_idx_d = (byte_idx_q == IDX_LAST) ? '0 : byte_idx_q + IDX_W'(1);
                        if (state_q == ST_LOCKED) begin
                            data_d  = lane_word;
                            valid_d = 1'b1;
                            sof_d   = (byte_idx_q == '0);
                        end
                    end
                    if (frame_slot) begin
                        if (state_q == ST_PRELOCK) begin
                            if (com_hit) begin
                                good_d = good_done ? '0 : good_inc;
                                bad_d  = '0;
                            end
                        end else begin
                            bad_d = com_hit ? '0 : bad_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        // Any fall back to SEARCH discards the alignment and all counters.
        if (state_q != ST_SEARCH && state_d == ST_SEARCH) begin
            bit_cnt_d  = '0;
            byte_idx_d = '0;
            good_d     = '0;
            bad_d      = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
        end
    end

endmodule
